// File: rtl/demod_rr_scheduler.sv
// demod_rr_scheduler
// Round-robin front end for a single shared FM discriminator. Up to N_CH
// complex baseband streams ({Q[31:16], I[15:0]}) are arbitrated one beat per
// grant. Each accepted beat is multiplied by the conjugate of the previous
// sample of its own channel, and the result is emitted tagged with its channel.
//
// Ports
//   s00_axis_aclk      sole clock
//   s00_axis_aresetn   synchronous active-low reset
//   ch_enable          per-channel arbitration mask (0 = never granted)
//   s00_axis_tvalid    per-channel valid
//   s00_axis_tdata     channel i at [32i+31:32i]
//   s00_axis_tlast     per-channel end of packet (clears that channel's history)
//   s00_axis_tready    per-channel ready, one-hot or zero
//   m00_axis_tready    downstream ready
//   m00_axis_tvalid    output valid
//   m00_axis_tdata     {imag[31:16], real[31:16]} of cur * conj(prev)
//   m00_axis_tlast     tlast of the source beat
//   m00_axis_tuser     source channel ID
//   m00_axis_tstrb     4'hF on every output beat
module demod_rr_scheduler #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic [N_CH-1:0]      ch_enable,
  input  logic [N_CH-1:0]      s00_axis_tvalid,
  input  logic [32*N_CH-1:0]   s00_axis_tdata,
  input  logic [N_CH-1:0]      s00_axis_tlast,
  output logic [N_CH-1:0]      s00_axis_tready,
  input  logic                 m00_axis_tready,
  output logic                 m00_axis_tvalid,
  output logic [31:0]          m00_axis_tdata,
  output logic                 m00_axis_tlast,
  output logic [CH_W-1:0]      m00_axis_tuser,
  output logic [3:0]           m00_axis_tstrb
);

  logic              adv, accept, any_cand;
  logic [N_CH-1:0]   cand;
  logic [CH_W-1:0]   grant, idx;
  logic [31:0]       grant_data;
  logic              grant_last;

  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]       hist_q [N_CH];
  logic [31:0]       hist_d [N_CH];

  logic              s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;
  logic [31:0]       s0_cur_q, s0_cur_d, s0_prev_q, s0_prev_d;
  logic [CH_W-1:0]   s0_ch_q, s0_ch_d;

  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [31:0] s1_ac_q, s1_ac_d, s1_bd_q, s1_bd_d;
  logic signed [31:0] s1_bc_q, s1_bc_d, s1_ad_q, s1_ad_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;

  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [3:0]        out_strb_q, out_strb_d;

  logic signed [31:0] cur_i, cur_q, prev_i, prev_q;

  // Mask is applied combinationally, so a channel disabled in the same cycle
  // as it would have been granted is skipped.
  always_comb begin
    cand     = s00_axis_tvalid & ch_enable;
    any_cand = |cand;
    grant    = '0;
    idx      = '0;
    // Walk from farthest to nearest so the nearest candidate after
    // last_grant is the final assignment.
    for (int k = N_CH; k >= 1; k--) begin
      idx = CH_W'((int'(last_grant_q) + k) % N_CH);
      if (cand[idx]) grant = idx;
    end
  end

  assign adv        = m00_axis_tready || !out_valid_q;
  assign accept     = s00_axis_aresetn && adv && any_cand;
  assign grant_data = s00_axis_tdata[32*int'(grant) +: 32];
  assign grant_last = s00_axis_tlast[grant];

  always_comb begin
    s00_axis_tready = '0;
    if (accept) s00_axis_tready[grant] = 1'b1;
  end

  assign cur_i  = {{16{s0_cur_q[15]}},  s0_cur_q[15:0]};
  assign cur_q  = {{16{s0_cur_q[31]}},  s0_cur_q[31:16]};
  assign prev_i = {{16{s0_prev_q[15]}}, s0_prev_q[15:0]};
  assign prev_q = {{16{s0_prev_q[31]}}, s0_prev_q[31:16]};

  always_comb begin
    last_grant_d = last_grant_q;
    hist_d       = hist_q;
    s0_valid_d = s0_valid_q; s0_cur_d = s0_cur_q; s0_prev_d = s0_prev_q;
    s0_ch_d    = s0_ch_q;    s0_last_d = s0_last_q;
    s1_valid_d = s1_valid_q; s1_ac_d = s1_ac_q; s1_bd_d = s1_bd_q;
    s1_bc_d    = s1_bc_q;    s1_ad_d = s1_ad_q; s1_ch_d = s1_ch_q;
    s1_last_d  = s1_last_q;
    out_valid_d = out_valid_q; out_data_d = out_data_q; out_ch_d = out_ch_q;
    out_last_d  = out_last_q;  out_strb_d = out_strb_q;

    if (accept) begin
      last_grant_d  = grant;
      hist_d[grant] = grant_last ? 32'h0 : grant_data;
    end

    if (adv) begin
      s0_valid_d = accept;
      s0_cur_d   = grant_data;
      s0_prev_d  = hist_q[grant];
      s0_ch_d    = grant;
      s0_last_d  = grant_last;

      // 16x16 signed products always fit in 32 bits.
      s1_valid_d = s0_valid_q;
      s1_ac_d    = cur_i * prev_i;
      s1_bd_d    = cur_q * prev_q;
      s1_bc_d    = cur_q * prev_i;
      s1_ad_d    = cur_i * prev_q;
      s1_ch_d    = s0_ch_q;
      s1_last_d  = s0_last_q;

      // 32-bit wrapping sums give the same bits [31:16] as the 33-bit sums.
      out_valid_d = s1_valid_q;
      out_data_d  = {16'((s1_bc_q - s1_ad_q) >> 16),
                     16'((s1_ac_q + s1_bd_q) >> 16)};
      out_ch_d    = s1_ch_q;
      out_last_d  = s1_last_q;
      out_strb_d  = s1_valid_q ? 4'hF : 4'h0;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      last_grant_q <= CH_W'(N_CH - 1);
      for (int i = 0; i < N_CH; i++) hist_q[i] <= '0;
      s0_valid_q <= 1'b0; s0_cur_q <= '0; s0_prev_q <= '0;
      s0_ch_q    <= '0;   s0_last_q <= 1'b0;
      s1_valid_q <= 1'b0; s1_ac_q <= '0; s1_bd_q <= '0;
      s1_bc_q    <= '0;   s1_ad_q <= '0; s1_ch_q <= '0; s1_last_q <= 1'b0;
      out_valid_q <= 1'b0; out_data_q <= '0; out_ch_q <= '0;
      out_last_q  <= 1'b0; out_strb_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hist_q       <= hist_d;
      s0_valid_q <= s0_valid_d; s0_cur_q <= s0_cur_d; s0_prev_q <= s0_prev_d;
      s0_ch_q    <= s0_ch_d;    s0_last_q <= s0_last_d;
      s1_valid_q <= s1_valid_d; s1_ac_q <= s1_ac_d; s1_bd_q <= s1_bd_d;
      s1_bc_q    <= s1_bc_d;    s1_ad_q <= s1_ad_d; s1_ch_q <= s1_ch_d;
      s1_last_q  <= s1_last_d;
      out_valid_q <= out_valid_d; out_data_q <= out_data_d; out_ch_q <= out_ch_d;
      out_last_q  <= out_last_d;  out_strb_q <= out_strb_d;
    end
  end

  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tuser  = out_ch_q;
  assign m00_axis_tstrb  = out_strb_q;

endmodule

// File: tb/tb_demod_rr_scheduler.sv
// Bench for demod_rr_scheduler: directed test-plan scenarios plus a random
// phase, all checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_demod_rr_scheduler;
  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                aresetn;
  logic [N_CH-1:0]     ch_enable, s_tvalid, s_tlast, s_tready;
  logic [32*N_CH-1:0]  s_tdata;
  logic                m_tready, m_tvalid, m_tlast;
  logic [31:0]         m_tdata;
  logic [CH_W-1:0]     m_tuser;
  logic [3:0]          m_tstrb;

  demod_rr_scheduler #(.N_CH(N_CH)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(aresetn), .ch_enable(ch_enable),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
    .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
    .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tdata(m_tdata), .m00_axis_tlast(m_tlast),
    .m00_axis_tuser(m_tuser), .m00_axis_tstrb(m_tstrb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Model: per-channel history, last grant, and a 3-slot latency line that
  // carries the finished discriminator result for each accepted beat.
  typedef struct { bit v; logic [31:0] d; int ch; bit l; } beat_t;
  typedef struct { logic [31:0] d; int ch; bit l; } out_t;
  logic [31:0] m_hist [N_CH];
  int          m_last;
  beat_t       m_pipe [3];
  int          m_acc;
  out_t        obs_q [$];

  function automatic logic [31:0] disc(input logic [31:0] cur, input logic [31:0] prev);
    longint ci, cq, pi, pq, re, im;
    ci = longint'($signed(cur[15:0]));   cq = longint'($signed(cur[31:16]));
    pi = longint'($signed(prev[15:0]));  pq = longint'($signed(prev[31:16]));
    re = ci * pi + cq * pq;
    im = cq * pi - ci * pq;
    return {im[31:16], re[31:16]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_hist[i] = '0;
    m_last = N_CH - 1;
    for (int i = 0; i < 3; i++) m_pipe[i] = '{v: 1'b0, d: '0, ch: 0, l: 1'b0};
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = (m_last + k) % N_CH;
      if (s_tvalid[c] && ch_enable[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N_CH-1:0] exp_tready();
    logic [N_CH-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (aresetn && (m_tready || !m_pipe[2].v) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic check_outputs();
    check_eq("s_tready", 32'(s_tready), 32'(exp_tready()));
    check_eq("m_tvalid", 32'(m_tvalid), 32'(m_pipe[2].v));
    if (m_pipe[2].v) begin
      check_eq("m_tdata", m_tdata, m_pipe[2].d);
      check_eq("m_tuser", 32'(m_tuser), 32'(m_pipe[2].ch));
      check_eq("m_tlast", 32'(m_tlast), 32'(m_pipe[2].l));
      check_eq("m_tstrb", 32'(m_tstrb), 32'hF);
    end
    if (m_tvalid && m_tready) obs_q.push_back('{d: m_tdata, ch: int'(m_tuser), l: m_tlast});
  endtask

  task automatic model_update();
    int g;
    logic [31:0] cur;
    m_acc = -1;
    if (!aresetn) model_reset();
    else if (m_tready || !m_pipe[2].v) begin
      g = model_grant();
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0].v = (g >= 0);
      if (g >= 0) begin
        cur = s_tdata[32*g +: 32];
        m_pipe[0].d  = disc(cur, m_hist[g]);
        m_pipe[0].ch = g;
        m_pipe[0].l  = s_tlast[g];
        m_hist[g]    = s_tlast[g] ? 32'h0 : cur;
        m_last       = g;
        m_acc        = g;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [31:0] d, input bit last);
    s_tvalid = '0; s_tlast = '0;
    s_tvalid[ch] = 1'b1;
    s_tlast[ch]  = last;
    s_tdata[32*ch +: 32] = d;
  endtask

  task automatic idle(input int n);
    s_tvalid = '0; s_tlast = '0;
    repeat (n) cycle();
  endtask

  function automatic logic [31:0] out_d(input int i);
    return (i < obs_q.size()) ? obs_q[i].d : 32'hDEAD_BEEF;
  endfunction

  function automatic int out_ch(input int i);
    return (i < obs_q.size()) ? obs_q[i].ch : -1;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;
    check_eq("rst_tvalid", 32'(m_tvalid), 32'h0);
    check_eq("rst_tdata",  m_tdata, 32'h0);
    check_eq("rst_tuser",  32'(m_tuser), 32'h0);
    check_eq("rst_tlast",  32'(m_tlast), 32'h0);
    check_eq("rst_tstrb",  32'(m_tstrb), 32'h0);
  endtask

  int rr_exp [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3};

  initial begin
    aresetn = 1'b0; ch_enable = '1; s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    m_tready = 1'b1; m_acc = -1;
    model_reset();
    cycle();
    do_reset();

    // Single channel: first output uses prev=0, second sees the first sample.
    obs_q.delete();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    idle(5);
    check_eq("t1_count", 32'(obs_q.size()), 32'd2);
    check_eq("t1_out0", out_d(0), 32'h0000_0000);
    check_eq("t1_out1", out_d(1), 32'h0000_1000);
    check_eq("t1_user1", 32'(out_ch(1)), 32'd0);

    // Quadrature rotation on channel 1.
    obs_q.delete();
    set_beat(1, 32'h0000_4000, 1'b0); cycle();
    set_beat(1, 32'h4000_0000, 1'b0); cycle();
    idle(5);
    check_eq("rot_out", out_d(1), 32'h1000_0000);
    check_eq("rot_user", 32'(out_ch(1)), 32'd1);

    // Full-scale negative on both parts: real sum reaches 2^31.
    obs_q.delete();
    set_beat(2, 32'h8000_8000, 1'b0); cycle();
    set_beat(2, 32'h8000_8000, 1'b0); cycle();
    idle(5);
    check_eq("ovf_out", out_d(1), 32'h0000_8000);

    // Round robin across all channels, then drop channel 2 mid-run.
    do_reset();
    obs_q.delete();
    ch_enable = '1; s_tvalid = '1; s_tlast = '0;
    for (int c = 0; c < N_CH; c++) s_tdata[32*c +: 32] = $urandom;
    for (int n = 0; n < 14; n++) begin
      if (n == 8) ch_enable[2] = 1'b0;
      cycle();
      if (m_acc >= 0) s_tdata[32*m_acc +: 32] = $urandom;
    end
    idle(5);
    check_eq("rr_count", 32'(obs_q.size()), 32'd14);
    for (int i = 0; i < 14; i++) check_eq("rr_user", 32'(out_ch(i)), 32'(rr_exp[i]));

    // Backpressure with the pipeline full.
    ch_enable = '1; s_tvalid = '1;
    repeat (4) begin
      cycle();
      if (m_acc >= 0) s_tdata[32*m_acc +: 32] = $urandom;
    end
    m_tready = 1'b0;
    repeat (5) begin
      cycle();
      check_eq("bp_tready", 32'(s_tready), 32'h0);
      check_eq("bp_tvalid", 32'(m_tvalid), 32'h1);
    end
    m_tready = 1'b1;
    repeat (4) begin
      cycle();
      if (m_acc >= 0) s_tdata[32*m_acc +: 32] = $urandom;
    end
    idle(5);

    // tlast clears history for the next beat of that channel.
    obs_q.delete();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    set_beat(0, 32'h0000_4000, 1'b1); cycle();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    idle(5);
    check_eq("tl_count", 32'(obs_q.size()), 32'd3);
    check_eq("tl_out1", out_d(1), 32'h0000_1000);
    check_eq("tl_out2", out_d(2), 32'h0000_0000);

    // Reset mid-stream drops in-flight beats and clears history.
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    do_reset();
    obs_q.delete();
    set_beat(0, 32'h0000_4000, 1'b0); cycle();
    idle(5);
    check_eq("prst_count", 32'(obs_q.size()), 32'd1);
    check_eq("prst_out", out_d(0), 32'h0000_0000);

    // Random traffic: masks, valids, tlast and downstream backpressure.
    for (int n = 0; n < 400; n++) begin
      ch_enable = N_CH'($urandom_range(0, 15) | ((n % 50 < 25) ? 15 : 0));
      s_tvalid  = N_CH'($urandom);
      s_tlast   = N_CH'($urandom & $urandom);
      for (int c = 0; c < N_CH; c++) s_tdata[32*c +: 32] = $urandom;
      m_tready  = ($urandom_range(0, 9) < 7);
      if (n == 200) aresetn = 1'b0;
      cycle();
      aresetn = 1'b1;
    end
    m_tready = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
